// File: rtl/mc_rdpath_pkg.sv
// mc_rdpath_pkg
// Shared types and helpers for the memory-controller DFI read-return path.
//   NPHASE     : DFI phases per controller clock (fixed at 4)
//   RD_DW      : per-phase read data width used by the beat-group type
//   rd_beat_t  : one PHY beat group as buffered in the read FIFO {mask, data}
//   clamp_lat  : maps the programmed read latency onto the supported range
package mc_rdpath_pkg;

    localparam int NPHASE = 4;
    localparam int RD_DW  = 32;

    // One returned beat group: which phases the PHY marked valid, plus all
    // phases' data packed with phase p at bits [p*RD_DW +: RD_DW].
    typedef struct packed {
        logic [NPHASE-1:0]       mask;
        logic [NPHASE*RD_DW-1:0] data;
    } rd_beat_t;

    // Latencies below 2 cannot be honoured because the PHY group must be
    // sampled and then popped on the following cycle; above max_lat the
    // delay line has no tap.
    function automatic logic [7:0] clamp_lat(input logic [7:0] cfg, input int max_lat);
        if (cfg < 8'd2) begin
            return 8'd2;
        end else if (int'(cfg) > max_lat) begin
            return max_lat[7:0];
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/rdbeat_fifo.sv
// rdbeat_fifo
// Synchronous FIFO of rd_beat_t with a first-word-fall-through head.
//   clk, rst   : clock, asynchronous active-high reset (FIFO empties)
//   push       : write push_beat at the tail (ignored when full unless a pop
//                happens in the same cycle)
//   push_beat  : beat group to store
//   pop        : discard the head (ignored when empty)
//   head       : current head entry, valid whenever empty is low
//   full/empty : occupancy flags
module rdbeat_fifo
    import mc_rdpath_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  rd_beat_t push_beat,
    input  logic     pop,
    output rd_beat_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so that equal low bits can be told apart
    // as either empty (MSBs equal) or full (MSBs differ) after wrap-around.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    rd_beat_t    mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so push+pop while full succeeds.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; these are the only state that needs resetting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_beat;
        end
    end

endmodule

// File: rtl/dfi_rddata_aligner.sv
// dfi_rddata_aligner
// Buffers PHY read beat groups and re-times them to a fixed, programmable
// latency after the core's rddata_en, tracking outstanding reads and
// flagging protocol errors.
//   clk, rst          : controller clock, asynchronous active-high reset
//   rd_lat_cfg        : cycles from rddata_en to aligned output valid
//   ctl_rddata_en     : per-phase read enable issued by the core
//   phy_rddata        : PHY read data, phase p at [p*DW +: DW]
//   phy_rddata_valid  : per-phase PHY valid
//   out_rddata        : aligned read data (0 when nothing is popped)
//   out_rddata_valid  : aligned per-phase valid, one cycle per issued group
//   outstanding       : issued groups not yet returned by the PHY
//   err_overflow      : sticky, PHY group dropped because the FIFO was full
//   err_underflow     : sticky, output slot arrived with an empty FIFO
//   err_spurious      : sticky, PHY data with nothing outstanding
//   err_mask          : sticky, returned mask differs from the issued mask
//   clr_err           : synchronous clear of all sticky flags
module dfi_rddata_aligner
    import mc_rdpath_pkg::*;
#(
    parameter int DW         = RD_DW,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_LAT    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rd_lat_cfg,
    input  logic [NPHASE-1:0]             ctl_rddata_en,
    input  logic [NPHASE*DW-1:0]          phy_rddata,
    input  logic [NPHASE-1:0]             phy_rddata_valid,
    output logic [NPHASE*DW-1:0]          out_rddata,
    output logic [NPHASE-1:0]             out_rddata_valid,
    output logic [$clog2(MAX_LAT+1):0]    outstanding,
    output logic                          err_overflow,
    output logic                          err_underflow,
    output logic                          err_spurious,
    output logic                          err_mask,
    input  logic                          clr_err
);

    // dl[i] holds the rddata_en mask issued i+1 cycles ago. The undelayed
    // input counts as stage 0, so tap L-1 is dl[L-2]; popping there and
    // registering the result lands the output exactly L cycles after issue.
    logic [NPHASE-1:0] dl [MAX_LAT-1];
    logic [7:0]        lat;
    logic [NPHASE-1:0] pop_mask;
    rd_beat_t          push_beat;
    rd_beat_t          head;
    logic              full;
    logic              empty;
    logic              issue;
    logic              phy_any;
    logic              pop_req;
    logic              pop_ok;
    logic              push_ok;
    logic              set_overflow;
    logic              set_underflow;
    logic              set_spurious;
    logic              set_mask;

    assign lat     = clamp_lat(rd_lat_cfg, MAX_LAT);
    assign issue   = |ctl_rddata_en;
    assign phy_any = |phy_rddata_valid;

    // Select the delay-line tap for the current effective latency.
    always_comb begin
        pop_mask = '0;
        for (int i = 0; i < MAX_LAT - 1; i++) begin
            if (lat == 8'(i + 2)) begin
                pop_mask = dl[i];
            end
        end
    end

    assign pop_req = |pop_mask;
    assign pop_ok  = pop_req && !empty;

    // A group issued this very cycle already counts as outstanding, which is
    // what lets the PHY answer in the issue cycle when L is 2.
    assign set_spurious  = phy_any && (outstanding == '0) && !issue;
    assign set_overflow  = phy_any && !set_spurious && full && !pop_ok;
    assign push_ok       = phy_any && !set_spurious && !set_overflow;
    assign set_underflow = pop_req && empty;
    assign set_mask      = pop_ok && (head.mask != pop_mask);

    assign push_beat.mask = phy_rddata_valid;
    assign push_beat.data = phy_rddata;

    rdbeat_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_beat (push_beat),
        .pop       (pop_req),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Delay line of issued masks, shifting every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAT - 1; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= ctl_rddata_en;
            for (int i = 1; i < MAX_LAT - 1; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    // Registered aligned outputs. On underflow the valid still follows the
    // issued mask so the core keeps its timing, but data is forced to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rddata_valid <= '0;
            out_rddata       <= '0;
        end else begin
            out_rddata_valid <= pop_mask;
            out_rddata       <= pop_ok ? head.data : '0;
        end
    end

    // Outstanding counter: saturating, and a dropped PHY group does not
    // count as a return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            if (issue && !push_ok && (outstanding != '1)) begin
                outstanding <= outstanding + 1'b1;
            end else if (!issue && push_ok && (outstanding != '0)) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_spurious  <= 1'b0;
            err_mask      <= 1'b0;
        end else begin
            err_overflow  <= set_overflow  || (err_overflow  && !clr_err);
            err_underflow <= set_underflow || (err_underflow && !clr_err);
            err_spurious  <= set_spurious  || (err_spurious  && !clr_err);
            err_mask      <= set_mask      || (err_mask      && !clr_err);
        end
    end

endmodule
